// File: rtl/memory_stage.sv
// MEM pipeline stage: little-endian data RAM with sub-word load extension and
// read-merge-write for half/byte stores, stalling the pipeline for two-cycle ops.
module memory_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_LSB    = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        R_Enable_In,
  input  logic        W_Enable_In,
  input  logic [1:0]  R_Width_In,
  input  logic [1:0]  W_Width_In,
  input  logic [31:0] ALUResult_In,
  input  logic [31:0] RegData2_In,
  output logic [31:0] ReadData_Out,
  output logic        Stall_Out,
  output logic        Error_Out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MERGE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_word_q;

  logic [AW-1:0] lat_idx_q;
  logic [1:0]    lat_off_q;
  logic [1:0]    lat_width_q;
  logic [15:0]   lat_data_q;

  logic [AW-1:0] addr_idx;
  logic [1:0]    addr_off;
  logic          unused_addr;

  logic          rd_en;
  logic          wr_en;
  logic          lat_en;
  logic          stall;
  logic          err;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [31:0]   load_word;
  logic [31:0]   merge_word;
  logic [31:0]   shifted;
  logic [4:0]    lane_shift;

  assign addr_idx    = ALUResult_In[ADDR_LSB +: AW];
  assign addr_off    = ALUResult_In[1:0];
  assign unused_addr = ^ALUResult_In;

  // Lane extraction and merge both work from the registered RAM word.
  always_comb begin
    lane_shift = {lat_off_q, 3'b000};
    shifted    = rd_word_q >> lane_shift;
    case (lat_width_q)
      2'b00:   load_word = rd_word_q;
      2'b01:   load_word = {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   load_word = {{24{shifted[7]}}, shifted[7:0]};
      default: load_word = {24'h0, shifted[7:0]};
    endcase
    merge_word = rd_word_q;
    if (lat_width_q == 2'b01) begin
      merge_word[{lat_off_q[1], 4'b0000} +: 16] = lat_data_q;
    end else begin
      merge_word[lane_shift +: 8] = lat_data_q[7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    err          = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    lat_en       = 1'b0;
    wr_idx       = addr_idx;
    wr_data      = RegData2_In;
    ReadData_Out = 32'h0;
    case (state_q)
      IDLE: begin
        if (Reset) begin
          state_d = IDLE;
        end else if (W_Enable_In) begin
          // A simultaneous load is dropped; the store still goes ahead.
          err = R_Enable_In;
          case (W_Width_In)
            2'b00: begin
              if (addr_off == 2'b00) wr_en = 1'b1;
              else                   err   = 1'b1;
            end
            2'b01, 2'b10: begin
              if (W_Width_In == 2'b01 && addr_off[0]) begin
                err = 1'b1;
              end else begin
                stall   = 1'b1;
                rd_en   = 1'b1;
                lat_en  = 1'b1;
                state_d = MERGE;
              end
            end
            default: err = 1'b1;
          endcase
        end else if (R_Enable_In) begin
          if ((R_Width_In == 2'b00 && addr_off != 2'b00) ||
              (R_Width_In == 2'b01 && addr_off[0])) begin
            err = 1'b1;
          end else begin
            stall   = 1'b1;
            rd_en   = 1'b1;
            lat_en  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        ReadData_Out = load_word;
        state_d      = IDLE;
      end
      MERGE: begin
        wr_en   = 1'b1;
        wr_idx  = lat_idx_q;
        wr_data = merge_word;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Stall_Out = stall;
  assign Error_Out = err;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      lat_idx_q   <= '0;
      lat_off_q   <= 2'b00;
      lat_width_q <= 2'b00;
      lat_data_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      if (lat_en) begin
        lat_idx_q   <= addr_idx;
        lat_off_q   <= addr_off;
        lat_width_q <= W_Enable_In ? W_Width_In : R_Width_In;
        lat_data_q  <= RegData2_In[15:0];
      end
    end
  end

  // RAM contents and its output register are deliberately not reset.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_word_q <= mem[addr_idx];
  end

endmodule
